// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the Phase-1 control sequencer: state encoding,
// opcode values, ALU op codes and IR field positions.
package cpu_ctrl_pkg;

  localparam int unsigned IR_W      = 32;
  localparam int unsigned OP_W      = 5;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned ALUOP_W   = 4;

  // IR field LSB positions; op = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15]
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_LSB = 15;

  typedef logic [OP_W-1:0]      opcode_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [ALUOP_W-1:0]   aluop_t;

  localparam opcode_t OP_ADD  = 5'd0;
  localparam opcode_t OP_SUB  = 5'd1;
  localparam opcode_t OP_AND  = 5'd2;
  localparam opcode_t OP_OR   = 5'd3;
  localparam opcode_t OP_SHR  = 5'd4;
  localparam opcode_t OP_SHL  = 5'd5;
  localparam opcode_t OP_ROR  = 5'd6;
  localparam opcode_t OP_ROL  = 5'd7;
  localparam opcode_t OP_MUL  = 5'd8;
  localparam opcode_t OP_DIV  = 5'd9;
  localparam opcode_t OP_HALT = 5'd31;

  localparam aluop_t ALUOP_INCA = 4'hF;

  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T2,
    T2B,
    T3,
    T4,
    T5,
    T6,
    HALTED
  } state_t;

  typedef struct packed {
    opcode_t  op;
    reg_idx_t ra;
    reg_idx_t rb;
    reg_idx_t rc;
  } ir_fields_t;

  // Slice the decoded fields out of the upper IR bits (ir[31:15]).
  function automatic ir_fields_t decode_ir(input logic [IR_W-1:RC_LSB] ir_hi);
    ir_fields_t f;
    f.op = ir_hi[OP_LSB +: OP_W];
    f.ra = ir_hi[RA_LSB +: REG_IDX_W];
    f.rb = ir_hi[RB_LSB +: REG_IDX_W];
    f.rc = ir_hi[RC_LSB +: REG_IDX_W];
    return f;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns a GPR index plus enable into a one-hot register select (all zero when disabled).
module reg_select_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 en,
  output logic [NUM_REGS-1:0]  sel
);

  assign sel = en ? (NUM_REGS'(1) << idx) : '0;

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired fetch/decode/execute sequencer driving the Phase-1 datapath strobes.
// Optional feature: define CU_RETIRE_CNT_EN to add the 'retired' instruction counter port.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255,
  parameter int unsigned START_IN_RUN = 0
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [IR_W-1:0]     ir,
  input  logic                mem_ready,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                PCin,
  output logic                PCout,
  output logic                MARin,
  output logic                MARout,
  output logic                IRin,
  output logic                IRout,
  output logic                Yin,
  output logic                Yout,
  output logic                MDRin,
  output logic                MDRout,
  output logic                HIin,
  output logic                HIout,
  output logic                LOin,
  output logic                LOout,
  output logic                Zhighin,
  output logic                Zlowin,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                Read,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic                ALU_MUL,
  output logic                ALU_DIV,
  output logic                busy,
  output logic                halted,
  output logic                fault
`ifdef CU_RETIRE_CNT_EN
  ,
  output logic [31:0]         retired
`endif
);

  localparam int unsigned    CNT_W     = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             fault_q, fault_d;

  ir_fields_t f;
  logic       ir_unused;
  logic       op_alu, op_mul, op_div, op_halt, op_legal;

  reg_idx_t rin_idx, rout_idx;
  logic     rin_en, rout_en;

  assign f         = decode_ir(ir[IR_W-1:RC_LSB]);
  assign ir_unused = ^ir[RC_LSB-1:0];

  assign op_alu   = f.op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL};
  assign op_mul   = (f.op == OP_MUL);
  assign op_div   = (f.op == OP_DIV);
  assign op_halt  = (f.op == OP_HALT);
  assign op_legal = op_alu | op_mul | op_div | op_halt;

  // Next-state, memory-wait counter and sticky fault.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (run || (START_IN_RUN != 0)) state_d = T0;
      end
      T0: begin
        state_d = T1;
        wait_d  = '0;
      end
      T1: begin
        if (mem_ready) begin
          state_d = T2;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = HALTED;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      T2:  state_d = T2B;
      T2B: state_d = T3;
      T3: begin
        if (!op_legal) begin
          state_d = HALTED;
          fault_d = 1'b1;
        end else if (op_halt) begin
          state_d = HALTED;
        end else begin
          state_d = T4;
        end
      end
      T4:      state_d = T5;
      T5:      state_d = (op_mul || op_div) ? T6 : T0;
      T6:      state_d = T0;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Strobes decode the state register and the live IR, so T3 sees the IR loaded at the end of T2B.
  always_comb begin
    rin_idx  = '0;
    rin_en   = 1'b0;
    rout_idx = '0;
    rout_en  = 1'b0;
    PCin     = 1'b0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    MARout   = 1'b0;
    IRin     = 1'b0;
    IRout    = 1'b0;
    Yin      = 1'b0;
    Yout     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    HIin     = 1'b0;
    HIout    = 1'b0;
    LOin     = 1'b0;
    LOout    = 1'b0;
    Zhighin  = 1'b0;
    Zlowin   = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    Read     = 1'b0;
    ALUop    = '0;
    ALU_MUL  = 1'b0;
    ALU_DIV  = 1'b0;
    case (state_q)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        Yin   = 1'b1;
      end
      T1: begin
        Yout   = 1'b1;
        ALUop  = ALUOP_INCA;
        Zlowin = 1'b1;
        Read   = 1'b1;
      end
      T2: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
      end
      T2B: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (op_legal && !op_halt) begin
          rout_en  = 1'b1;
          rout_idx = f.rb;
          Yin      = 1'b1;
        end
      end
      T4: begin
        rout_en  = 1'b1;
        rout_idx = f.rc;
        Zlowin   = 1'b1;
        if (op_mul) begin
          ALU_MUL = 1'b1;
          Zhighin = 1'b1;
        end else if (op_div) begin
          ALU_DIV = 1'b1;
          Zhighin = 1'b1;
        end else if (op_alu) begin
          ALUop = {1'b0, f.op[2:0]};
        end
      end
      T5: begin
        Zlowout = 1'b1;
        if (op_mul || op_div) begin
          LOin = 1'b1;
        end else begin
          rin_en  = 1'b1;
          rin_idx = f.ra;
        end
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
    // MDR only captures memory data on the cycle the read completes.
    MDRin = Read & mem_ready;
  end

  assign busy   = (state_q != IDLE) && (state_q != HALTED);
  assign halted = (state_q == HALTED);
  assign fault  = fault_q;

  reg_select_decoder u_rin_dec (
    .idx (rin_idx),
    .en  (rin_en),
    .sel (Rin)
  );

  reg_select_decoder u_rout_dec (
    .idx (rout_idx),
    .en  (rout_en),
    .sel (Rout)
  );

`ifdef CU_RETIRE_CNT_EN
  logic [31:0] retired_q;

  // Counts instructions on their final execute cycle; wraps naturally.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      retired_q <= '0;
    end else if (((state_q == T5) && op_alu) || (state_q == T6)) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed cycle-by-cycle check of the control sequencer strobes, status and wait/fault paths.
module tb_cpu_control_unit;

  logic        clock;
  logic        clear;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] Rin, Rout;
  logic PCin, PCout, MARin, MARout, IRin, IRout, Yin, Yout;
  logic MDRin, MDRout, HIin, HIout, LOin, LOout;
  logic Zhighin, Zlowin, Zhighout, Zlowout, Read;
  logic [3:0] ALUop;
  logic ALU_MUL, ALU_DIV, busy, halted, fault;
`ifdef CU_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Special-register strobes, {PCin,PCout,MARin,MARout,IRin,IRout,Yin,Yout,MDRin,MDRout,HIin,HIout,LOin,LOout}
  localparam logic [13:0] PCIN   = 14'h2000;
  localparam logic [13:0] PCOUT  = 14'h1000;
  localparam logic [13:0] MARIN  = 14'h0800;
  localparam logic [13:0] IRIN   = 14'h0200;
  localparam logic [13:0] YIN    = 14'h0080;
  localparam logic [13:0] YOUT   = 14'h0040;
  localparam logic [13:0] MDRIN  = 14'h0020;
  localparam logic [13:0] MDROUT = 14'h0010;
  localparam logic [13:0] HIIN   = 14'h0008;
  localparam logic [13:0] LOIN   = 14'h0002;
  // Z strobes {Zhighin,Zlowin,Zhighout,Zlowout}
  localparam logic [3:0] ZHIN  = 4'h8;
  localparam logic [3:0] ZLIN  = 4'h4;
  localparam logic [3:0] ZHOUT = 4'h2;
  localparam logic [3:0] ZLOUT = 4'h1;
  // Status {busy,halted,fault}
  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_BUSY = 3'b100;
  localparam logic [2:0] ST_HLT  = 3'b010;
  localparam logic [2:0] ST_HLTF = 3'b011;

  logic [59:0] obs;
  assign obs = {Rin, Rout, PCin, PCout, MARin, MARout, IRin, IRout, Yin, Yout,
                MDRin, MDRout, HIin, HIout, LOin, LOout,
                Zhighin, Zlowin, Zhighout, Zlowout, Read, ALUop, ALU_MUL, ALU_DIV,
                busy, halted, fault};

  cpu_control_unit #(
    .MEM_WAIT_MAX (4),
    .START_IN_RUN (0)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .run       (run),
    .ir        (ir),
    .mem_ready (mem_ready),
    .Rin       (Rin),
    .Rout      (Rout),
    .PCin      (PCin),
    .PCout     (PCout),
    .MARin     (MARin),
    .MARout    (MARout),
    .IRin      (IRin),
    .IRout     (IRout),
    .Yin       (Yin),
    .Yout      (Yout),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .HIin      (HIin),
    .HIout     (HIout),
    .LOin      (LOin),
    .LOout     (LOout),
    .Zhighin   (Zhighin),
    .Zlowin    (Zlowin),
    .Zhighout  (Zhighout),
    .Zlowout   (Zlowout),
    .Read      (Read),
    .ALUop     (ALUop),
    .ALU_MUL   (ALU_MUL),
    .ALU_DIV   (ALU_DIV),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault)
`ifdef CU_RETIRE_CNT_EN
    ,
    .retired   (retired)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [59:0] w(input logic [15:0] rin, input logic [15:0] rout,
                                    input logic [13:0] sp, input logic [3:0] z,
                                    input logic rd, input logic [3:0] alu,
                                    input logic [1:0] md, input logic [2:0] st);
    return {rin, rout, sp, z, rd, alu, md, st};
  endfunction

  // Inputs are set at posedge+2; outputs checked at posedge+3.
  task automatic cyc(input string tag, input logic [59:0] exp);
    #1 check(tag, 64'(obs), 64'(exp));
    @(posedge clock);
    #2;
  endtask

  task automatic fetch(input int waits);
    mem_ready = 1'b1;
    cyc("t0", w(16'h0, 16'h0, PCOUT | MARIN | YIN, 4'h0, 1'b0, 4'h0, 2'b00, ST_BUSY));
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      cyc("t1_wait", w(16'h0, 16'h0, YOUT, ZLIN, 1'b1, 4'hF, 2'b00, ST_BUSY));
    end
    mem_ready = 1'b1;
    cyc("t1_ready", w(16'h0, 16'h0, YOUT | MDRIN, ZLIN, 1'b1, 4'hF, 2'b00, ST_BUSY));
    cyc("t2", w(16'h0, 16'h0, PCIN, ZLOUT, 1'b0, 4'h0, 2'b00, ST_BUSY));
    cyc("t2b", w(16'h0, 16'h0, MDROUT | IRIN, 4'h0, 1'b0, 4'h0, 2'b00, ST_BUSY));
  endtask

  task automatic alu_exec(input logic [15:0] ra_m, input logic [15:0] rb_m,
                          input logic [15:0] rc_m, input logic [3:0] alu);
    cyc("t3_alu", w(16'h0, rb_m, YIN, 4'h0, 1'b0, 4'h0, 2'b00, ST_BUSY));
    cyc("t4_alu", w(16'h0, rc_m, 14'h0, ZLIN, 1'b0, alu, 2'b00, ST_BUSY));
    cyc("t5_alu", w(ra_m, 16'h0, 14'h0, ZLOUT, 1'b0, 4'h0, 2'b00, ST_BUSY));
  endtask

  task automatic muldiv_exec(input logic [15:0] rb_m, input logic [15:0] rc_m,
                             input logic [1:0] md);
    cyc("t3_md", w(16'h0, rb_m, YIN, 4'h0, 1'b0, 4'h0, 2'b00, ST_BUSY));
    cyc("t4_md", w(16'h0, rc_m, 14'h0, ZHIN | ZLIN, 1'b0, 4'h0, md, ST_BUSY));
    cyc("t5_md", w(16'h0, 16'h0, LOIN, ZLOUT, 1'b0, 4'h0, 2'b00, ST_BUSY));
    cyc("t6_md", w(16'h0, 16'h0, HIIN, ZHOUT, 1'b0, 4'h0, 2'b00, ST_BUSY));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  initial begin
    clear     = 1'b1;
    run       = 1'b0;
    ir        = 32'h0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    cyc("reset", 60'h0);
    clear = 1'b0;
    cyc("idle", 60'h0);

    // add R1,R2,R3 with zero memory wait
    ir        = 32'h0091_8000;
    mem_ready = 1'b1;
    run       = 1'b1;
    cyc("idle_run", 60'h0);
    run = 1'b0;
    fetch(0);
    alu_exec(16'h0002, 16'h0004, 16'h0008, 4'h0);

    // mul R0,R4,R5; run held high while busy must be ignored
    ir  = {5'd8, 4'd0, 4'd4, 4'd5, 15'd0};
    run = 1'b1;
    fetch(0);
    muldiv_exec(16'h0010, 16'h0020, 2'b10);
    run = 1'b0;

    // sub R7,R6,R5 with three memory wait cycles
    ir = {5'd1, 4'd7, 4'd6, 4'd5, 15'd0};
    fetch(3);
    alu_exec(16'h0080, 16'h0040, 16'h0020, 4'h1);

    // halt: no strobes in T3, then parked in HALTED without fault, run ignored
    ir = 32'hF800_0000;
    fetch(0);
    cyc("t3_halt", w(16'h0, 16'h0, 14'h0, 4'h0, 1'b0, 4'h0, 2'b00, ST_BUSY));
    run = 1'b1;
    cyc("halted_run", w(16'h0, 16'h0, 14'h0, 4'h0, 1'b0, 4'h0, 2'b00, ST_HLT));
    run = 1'b0;
    cyc("halted", w(16'h0, 16'h0, 14'h0, 4'h0, 1'b0, 4'h0, 2'b00, ST_HLT));
`ifdef CU_RETIRE_CNT_EN
    check("retired_three", 64'(retired), 64'd3);
`endif

    clear = 1'b1;
    cyc("clear_halted", 60'h0);
    clear = 1'b0;
`ifdef CU_RETIRE_CNT_EN
    check("retired_cleared", 64'(retired), 64'd0);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    check("retired_preload", 64'(retired), 64'hFFFF_FFFF);
    ir  = 32'h0091_8000;
    run = 1'b1;
    cyc("idle_wrap", 60'h0);
    run = 1'b0;
    fetch(0);
    alu_exec(16'h0002, 16'h0004, 16'h0008, 4'h0);
    check("retired_wrap", 64'(retired), 64'd0);
    clear = 1'b1;
    cyc("clear_wrap", 60'h0);
    clear = 1'b0;
`endif

    // illegal opcode 20: no strobes in T3, then HALTED with fault
    ir  = {5'd20, 27'd0};
    run = 1'b1;
    cyc("idle_ill", 60'h0);
    run = 1'b0;
    fetch(0);
    cyc("t3_illegal", w(16'h0, 16'h0, 14'h0, 4'h0, 1'b0, 4'h0, 2'b00, ST_BUSY));
    cyc("halted_ill", w(16'h0, 16'h0, 14'h0, 4'h0, 1'b0, 4'h0, 2'b00, ST_HLTF));
    cyc("halted_ill2", w(16'h0, 16'h0, 14'h0, 4'h0, 1'b0, 4'h0, 2'b00, ST_HLTF));
    clear = 1'b1;
    cyc("clear_fault", 60'h0);
    clear = 1'b0;

    // memory never ready: four wait cycles then timeout fault
    ir  = 32'h0091_8000;
    run = 1'b1;
    cyc("idle_to", 60'h0);
    run       = 1'b0;
    mem_ready = 1'b0;
    cyc("t0_to", w(16'h0, 16'h0, PCOUT | MARIN | YIN, 4'h0, 1'b0, 4'h0, 2'b00, ST_BUSY));
    for (int i = 0; i < 4; i++) begin
      cyc("t1_to", w(16'h0, 16'h0, YOUT, ZLIN, 1'b1, 4'hF, 2'b00, ST_BUSY));
    end
    cyc("halted_to", w(16'h0, 16'h0, 14'h0, 4'h0, 1'b0, 4'h0, 2'b00, ST_HLTF));
    clear = 1'b1;
    cyc("clear_to", 60'h0);
    clear = 1'b0;

    // asynchronous clear while waiting in T1
    run = 1'b1;
    cyc("idle_ac", 60'h0);
    run = 1'b0;
    cyc("t0_ac", w(16'h0, 16'h0, PCOUT | MARIN | YIN, 4'h0, 1'b0, 4'h0, 2'b00, ST_BUSY));
    cyc("t1_ac", w(16'h0, 16'h0, YOUT, ZLIN, 1'b1, 4'hF, 2'b00, ST_BUSY));
    clear = 1'b1;
    cyc("clear_async", 60'h0);
    clear     = 1'b0;
    mem_ready = 1'b1;
    cyc("idle_after_clear", 60'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
